// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// pipe_pkg: shared state encoding and per-stage payload widths for the
// pipelined CPU inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
// Revision: 1.0 - initial release
// ============================================================================
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  localparam logic [31:0] PIPE_PC_RESET = 32'h8000_0000;

  localparam int IFID_CTRL_W  = 8;
  localparam int IFID_DATA_W  = 32;
  localparam int IDEX_CTRL_W  = 24;
  localparam int IDEX_DATA_W  = 128;
  localparam int EXMEM_CTRL_W = 16;
  localparam int EXMEM_DATA_W = 72;
  localparam int MEMWB_CTRL_W = 8;
  localparam int MEMWB_DATA_W = 69;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_stage_entry.sv
`default_nettype none
// ============================================================================
// pipe_stage_entry: clearable {pc, ctrl, data} payload register with load.
// Revision: 1.0 - initial release
// ============================================================================
module pipe_stage_entry #(
  parameter int              PC_W     = 32,
  parameter int              CTRL_W   = 24,
  parameter int              DATA_W   = 128,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic [PC_W-1:0]   d_pc,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [DATA_W-1:0] d_data,
  output logic [PC_W-1:0]   q_pc,
  output logic [CTRL_W-1:0] q_ctrl,
  output logic [DATA_W-1:0] q_data
);

  // clear wins over load so a flush always leaves a clean bubble
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_pc   <= RESET_PC;
      q_ctrl <= '0;
      q_data <= '0;
    end else if (clear) begin
      q_pc   <= '0;
      q_ctrl <= '0;
      q_data <= '0;
    end else if (load) begin
      q_pc   <= d_pc;
      q_ctrl <= d_ctrl;
      q_data <= d_data;
    end
  end

endmodule : pipe_stage_entry
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// pipe_stage_reg: generic inter-stage register with valid/ready handshake and
// a 2-entry skid buffer. Optional perf counters under PIPE_STAGE_PERF_EN.
// Revision: 1.0 - initial release
// ============================================================================
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter int              CTRL_W   = IDEX_CTRL_W,
  parameter int              DATA_W   = IDEX_DATA_W,
  parameter logic [PC_W-1:0] PC_RESET = PC_W'(PIPE_PC_RESET)
`ifdef PIPE_STAGE_PERF_EN
  ,
  parameter int              CNT_W    = 16
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
`endif
);

  state_t state, state_nxt;

  logic              in_fire, out_fire;
  logic              main_load, main_from_skid, skid_load;
  logic [PC_W-1:0]   main_pc,   skid_pc,   main_d_pc;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_d_ctrl;
  logic [DATA_W-1:0] main_data, skid_data, main_d_data;

  assign out_valid = (state != ST_EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_nxt      = state;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    if (flush) begin
      state_nxt = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_fire) begin
            main_load = 1'b1;
            state_nxt = ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_load = 1'b1;
          end else if (in_fire) begin
            skid_load = 1'b1;
            state_nxt = ST_FULL;
          end else if (out_fire) begin
            state_nxt = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            state_nxt      = ST_ONE;
          end
        end
        default: state_nxt = ST_EMPTY;
      endcase
    end
  end

  // in_ready is precomputed from the next state so back-pressure is a flop
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_EMPTY;
      in_ready <= 1'b1;
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt != ST_FULL);
    end
  end

  assign main_d_pc   = main_from_skid ? skid_pc   : in_pc;
  assign main_d_ctrl = main_from_skid ? skid_ctrl : in_ctrl;
  assign main_d_data = main_from_skid ? skid_data : in_data;

  pipe_stage_entry #(
    .PC_W     (PC_W),
    .CTRL_W   (CTRL_W),
    .DATA_W   (DATA_W),
    .RESET_PC (PC_RESET)
  ) u_main (
    .clk    (clk),
    .reset  (reset),
    .load   (main_load),
    .clear  (flush),
    .d_pc   (main_d_pc),
    .d_ctrl (main_d_ctrl),
    .d_data (main_d_data),
    .q_pc   (main_pc),
    .q_ctrl (main_ctrl),
    .q_data (main_data)
  );

  pipe_stage_entry #(
    .PC_W     (PC_W),
    .CTRL_W   (CTRL_W),
    .DATA_W   (DATA_W),
    .RESET_PC ('0)
  ) u_skid (
    .clk    (clk),
    .reset  (reset),
    .load   (skid_load),
    .clear  (flush),
    .d_pc   (in_pc),
    .d_ctrl (in_ctrl),
    .d_data (in_data),
    .q_pc   (skid_pc),
    .q_ctrl (skid_ctrl),
    .q_data (skid_data)
  );

  assign out_pc   = main_pc;
  assign out_data = main_data;
  assign out_ctrl = out_valid ? main_ctrl : '0;

`ifdef PIPE_STAGE_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (!out_valid && (bubble_cnt != '1))
        bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end
`endif

endmodule : pipe_stage_reg
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// tb_pipe_stage_reg: directed self-checking bench for pipe_stage_reg.
// Revision: 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

  localparam int PC_W   = 32;
  localparam int CTRL_W = 24;
  localparam int DATA_W = 128;

  logic              clk = 1'b0;
  logic              reset;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [PC_W-1:0]   in_pc;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [PC_W-1:0]   out_pc;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
`ifdef PIPE_STAGE_PERF_EN
  logic [3:0]        stall_cnt;
  logic [3:0]        bubble_cnt;
`endif

  int checks = 0;
  int errs   = 0;

  always #5 clk = ~clk;

`ifdef PIPE_STAGE_PERF_EN
  pipe_stage_reg #(.PC_W(PC_W), .CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(4)) dut (
`else
  pipe_stage_reg #(.PC_W(PC_W), .CTRL_W(CTRL_W), .DATA_W(DATA_W)) dut (
`endif
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pc      (in_pc),
    .in_ctrl    (in_ctrl),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pc     (out_pc),
    .out_ctrl   (out_ctrl),
    .out_data   (out_data)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
`endif
  );

  function automatic logic [CTRL_W-1:0] ctrl_of(input logic [PC_W-1:0] pc);
    return {8'hA5, pc[15:0]};
  endfunction

  function automatic logic [DATA_W-1:0] data_of(input logic [PC_W-1:0] pc);
    return {pc, ~pc, pc, 32'hC0DE_0000 | pc};
  endfunction

  task automatic drive(input logic v, input logic [PC_W-1:0] pc);
    in_valid = v;
    in_pc    = pc;
    in_ctrl  = ctrl_of(pc);
    in_data  = data_of(pc);
  endtask

  // advance one clock; outputs are then sampled 1ns after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, '0);
    step(); step();
    checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL rst_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errs++; $display("FAIL rst_ready: got %b expected 1", in_ready); end
    checks++; if (out_pc !== 32'h8000_0000) begin errs++; $display("FAIL rst_pc: got %h expected 80000000", out_pc); end
    checks++; if (out_ctrl !== '0) begin errs++; $display("FAIL rst_ctrl: got %h expected 0", out_ctrl); end
    checks++; if (out_data !== '0) begin errs++; $display("FAIL rst_data: got %h expected 0", out_data); end
    #3 reset = 1'b1;
  endtask

  task automatic test_streaming();
    logic [PC_W-1:0] pc;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pc = 32'h100 + 32'(4 * i);
      drive(1'b1, pc);
      step();
      checks++; if (out_valid !== 1'b1 || out_pc !== pc) begin errs++; $display("FAIL stream_beat%0d: got v=%b pc=%h expected v=1 pc=%h", i, out_valid, out_pc, pc); end
      checks++; if (out_ctrl !== ctrl_of(pc) || out_data !== data_of(pc)) begin errs++; $display("FAIL stream_payload%0d: got ctrl=%h data=%h expected ctrl=%h data=%h", i, out_ctrl, out_data, ctrl_of(pc), data_of(pc)); end
      checks++; if (in_ready !== 1'b1) begin errs++; $display("FAIL stream_ready%0d: got %b expected 1", i, in_ready); end
    end
    drive(1'b0, '0);
    step();
    checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL stream_drain: got valid=%b expected 0", out_valid); end
  endtask

  task automatic test_back_pressure();
    out_ready = 1'b0;
    drive(1'b1, 32'h200);
    step();
    checks++; if (out_pc !== 32'h200 || in_ready !== 1'b1) begin errs++; $display("FAIL bp_first: got pc=%h rdy=%b expected pc=200 rdy=1", out_pc, in_ready); end
    drive(1'b1, 32'h204);
    step();
    checks++; if (out_pc !== 32'h200 || in_ready !== 1'b0 || out_valid !== 1'b1) begin errs++; $display("FAIL bp_full: got pc=%h rdy=%b v=%b expected pc=200 rdy=0 v=1", out_pc, in_ready, out_valid); end
    drive(1'b1, 32'h208);
    step();
    checks++; if (out_pc !== 32'h200 || in_ready !== 1'b0) begin errs++; $display("FAIL bp_hold: got pc=%h rdy=%b expected pc=200 rdy=0", out_pc, in_ready); end
    out_ready = 1'b1;
    step();
    checks++; if (out_pc !== 32'h204 || out_ctrl !== ctrl_of(32'h204) || in_ready !== 1'b1) begin errs++; $display("FAIL bp_skid: got pc=%h ctrl=%h rdy=%b expected pc=204 ctrl=%h rdy=1", out_pc, out_ctrl, in_ready, ctrl_of(32'h204)); end
    step();
    checks++; if (out_pc !== 32'h208 || out_valid !== 1'b1) begin errs++; $display("FAIL bp_third: got pc=%h v=%b expected pc=208 v=1", out_pc, out_valid); end
    drive(1'b0, '0);
    step();
    checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL bp_drain: got valid=%b expected 0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(1'b1, 32'h2F0); step();
    drive(1'b1, 32'h2F4); step();
    checks++; if (in_ready !== 1'b0) begin errs++; $display("FAIL flush_prefull: got rdy=%b expected 0", in_ready); end
    drive(1'b1, 32'h300);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, '0);
    checks++; if (out_valid !== 1'b0 || out_ctrl !== '0 || in_ready !== 1'b1) begin errs++; $display("FAIL flush_full: got v=%b ctrl=%h rdy=%b expected v=0 ctrl=0 rdy=1", out_valid, out_ctrl, in_ready); end
    checks++; if (out_pc !== '0 || out_data !== '0) begin errs++; $display("FAIL flush_clear: got pc=%h data=%h expected 0", out_pc, out_data); end
    out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0 || out_pc === 32'h300) begin errs++; $display("FAIL flush_discard: got v=%b pc=%h expected v=0 and no 300", out_valid, out_pc); end
    out_ready = 1'b0;
    drive(1'b1, 32'h310); step();
    drive(1'b1, 32'h314);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, '0);
    out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0 || out_pc !== '0 || in_ready !== 1'b1) begin errs++; $display("FAIL flush_one: got v=%b pc=%h rdy=%b expected v=0 pc=0 rdy=1", out_valid, out_pc, in_ready); end
  endtask

  task automatic test_bubble_ctrl();
    in_valid = 1'b0;
    in_ctrl  = 24'hFF_FFFF;
    step();
    step();
    checks++; if (out_ctrl !== '0 || out_valid !== 1'b0) begin errs++; $display("FAIL bubble_ctrl: got v=%b ctrl=%h expected v=0 ctrl=0", out_valid, out_ctrl); end
  endtask

  task automatic test_reset_mid_transfer();
    out_ready = 1'b0;
    drive(1'b1, 32'h400); step();
    drive(1'b1, 32'h404); step();
    checks++; if (in_ready !== 1'b0 || out_pc !== 32'h400) begin errs++; $display("FAIL mid_prefull: got rdy=%b pc=%h expected rdy=0 pc=400", in_ready, out_pc); end
    #2 reset = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_ctrl !== '0 || in_ready !== 1'b1) begin errs++; $display("FAIL mid_rst: got v=%b ctrl=%h rdy=%b expected v=0 ctrl=0 rdy=1", out_valid, out_ctrl, in_ready); end
    checks++; if (out_pc !== 32'h8000_0000 || out_data !== '0) begin errs++; $display("FAIL mid_rst_pc: got pc=%h data=%h expected pc=80000000 data=0", out_pc, out_data); end
    drive(1'b0, '0);
    #1 reset = 1'b1;
  endtask

`ifdef PIPE_STAGE_PERF_EN
  task automatic test_perf();
    #1;
    checks++; if (stall_cnt !== 4'd0 || bubble_cnt !== 4'd0) begin errs++; $display("FAIL perf_rst: got stall=%0d bubble=%0d expected 0 0", stall_cnt, bubble_cnt); end
    out_ready = 1'b0;
    drive(1'b1, 32'h500);
    step();
    drive(1'b0, '0);
    repeat (5) step();
    checks++; if (stall_cnt !== 4'd5 || bubble_cnt !== 4'd1) begin errs++; $display("FAIL perf_stall: got stall=%0d bubble=%0d expected 5 1", stall_cnt, bubble_cnt); end
    out_ready = 1'b1;
    step();
    repeat (20) step();
    checks++; if (bubble_cnt !== 4'd15 || stall_cnt !== 4'd5) begin errs++; $display("FAIL perf_sat: got bubble=%0d stall=%0d expected 15 5", bubble_cnt, stall_cnt); end
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++; if (bubble_cnt !== 4'd15 || stall_cnt !== 4'd5) begin errs++; $display("FAIL perf_flush: got bubble=%0d stall=%0d expected 15 5", bubble_cnt, stall_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_streaming();
    test_back_pressure();
    test_flush();
    test_bubble_ctrl();
    test_reset_mid_transfer();
`ifdef PIPE_STAGE_PERF_EN
    test_perf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_pipe_stage_reg
`default_nettype wire

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised successor to the fixed ID/EX-style stage register; generic inter-stage register for the pipelined CPU (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries PC, control and data payloads with a valid/ready handshake and a 2-entry skid buffer, so stall back-pressure is registered and never combinationally chained across stages.
- Separates hold (stall, no data loss) from flush (kill, insert bubble); a bubble presents all-zero control so downstream stages do no writes.

Parameters:
- PC_W, 32, PC field width.
- CTRL_W, 24, control-bundle width (RegWrite, MemRead, MemWrite, ALUOp, ...); forced to 0 whenever out_valid=0.
- DATA_W, 128, data-bundle width (operands, immediate, register indices).
- PC_RESET, 32'h8000_0000, out_pc value after reset.
- CNT_W, 16, perf counter width (optional feature only).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  kill all held entries this edge.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  stage can accept; registered.
- in_pc  in  PC_W  upstream PC.
- in_ctrl  in  CTRL_W  upstream control bundle.
- in_data  in  DATA_W  upstream data bundle.
- out_valid  out  1  beat valid to downstream.
- out_ready  in  1  downstream accepts.
- out_pc  out  PC_W  held PC.
- out_ctrl  out  CTRL_W  held control; 0 when !out_valid.
- out_data  out  DATA_W  held data.
- stall_cnt  out  CNT_W  (PIPE_STAGE_PERF_EN only) cycles with out_valid & !out_ready.
- bubble_cnt  out  CNT_W  (PIPE_STAGE_PERF_EN only) cycles with !out_valid.

Behaviour:
- Storage: main entry (drives outputs) plus skid entry. in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- State machine, 2-bit: EMPTY, ONE (main only), FULL (main + skid).
  - EMPTY: in_fire -> load main, go ONE.
  - ONE: in_fire & out_fire -> replace main, stay ONE. in_fire only -> load skid, go FULL. out_fire only -> go EMPTY.
  - FULL: in_ready=0. out_fire -> main <= skid, go ONE. No out_fire -> hold.
- in_ready = (state != FULL), taken from a register. Latency is 1 cycle from in_fire to out_valid. Full throughput is 1 beat/cycle.
- out_valid = (state != EMPTY). out_ctrl = out_valid ? main_ctrl : 0. out_pc and out_data are held registers; they are not gated.
- Ordering is strict FIFO; no beat is duplicated or dropped except by flush.
- flush takes priority over all handshakes at the same edge:
  - next state EMPTY; main and skid ctrl cleared; out_pc and out_data cleared to 0.
  - A beat offered in the flush cycle is discarded, even if in_ready=1.
  - in_ready=1 on the following cycle.
- Reset (reset=0, asynchronous, any time including mid-transfer):
  - state EMPTY, out_valid=0, in_ready=1, out_ctrl=0, out_data=0, skid cleared, out_pc=PC_RESET.
  - Perf counters cleared.
  - Deassertion is synchronised by the top-level reset synchroniser.
- Downstream must not depend on out_ready being stable while out_valid=0. Upstream must hold in_* stable while in_valid & !in_ready.

Optional Feature:
- Macro PIPE_STAGE_PERF_EN.
- Defined: stall_cnt and bubble_cnt ports exist. Each increments by 1 per qualifying cycle, saturates at all-ones, and is cleared by reset only (not by flush).
- Undefined: ports and counters are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package pipe_pkg: state encoding (ST_EMPTY=2'd0, ST_ONE=2'd1, ST_FULL=2'd2), PC_RESET default constant, and per-stage CTRL_W/DATA_W constants used by the top level to instantiate IF/ID, ID/EX, EX/MEM and MEM/WB.
- One sub-module is natural: pipe_stage_entry, a clearable payload register {pc, ctrl, data} with load and clear inputs. It is instantiated twice, once for main and once for skid.

Test Plan:
- Reset: assert reset=0 mid-transfer with state FULL -> immediately out_valid=0, out_ctrl=0, out_pc=32'h8000_0000, in_ready=1.
- Streaming: out_ready=1, send pc 0x100, 0x104, 0x108 on consecutive cycles -> same pcs appear one cycle later, back-to-back, in_ready stays 1.
- Back-pressure: hold out_ready=0, send 0x200 then 0x204 -> state FULL, in_ready=0 on the next cycle, 0x208 held upstream. Release out_ready -> output order 0x200, 0x204, 0x208 with no loss.
- Flush in FULL while offering 0x300 with in_valid=1 -> next cycle out_valid=0, out_ctrl=0, out_pc=0, in_ready=1, and 0x300 never appears.
- Bubble control: in_ctrl=24'hFFFFFF with in_valid=0 -> out_ctrl stays 0.
- With PIPE_STAGE_PERF_EN: 5 cycles out_valid=1 with out_ready=0 -> stall_cnt=5. With CNT_W=4, 20 idle cycles -> bubble_cnt saturates at 15.
